// File: rtl/jacobi_feeder_pkg.sv
// Constants shared between the Jacobi feeder and the solver it drives:
// word width, largest system size, Q.8 fraction width and feeder state codes.
package jacobi_feeder_pkg;

    localparam int FEEDER_DATA_W = 27;
    localparam int MAX_N         = 200;
    localparam int Q_FRAC_W      = 8;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_GO_HI  = 4'd1;
    localparam logic [3:0] ST_GO_GAP = 4'd2;
    localparam logic [3:0] ST_B_HI   = 4'd3;
    localparam logic [3:0] ST_B_LO   = 4'd4;
    localparam logic [3:0] ST_AB_GAP = 4'd5;
    localparam logic [3:0] ST_A_HI   = 4'd6;
    localparam logic [3:0] ST_A_LO   = 4'd7;
    localparam logic [3:0] ST_FIN    = 4'd8;

    function automatic logic n_is_valid(input logic [7:0] n_v);
        return (n_v != 8'd0) && (n_v <= 8'(MAX_N));
    endfunction

endpackage

// File: rtl/jacobi_feeder_sync_fifo.sv
// Show-ahead synchronous FIFO used as the feeder's input skid buffer.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push_s;
    logic             do_pop_s;

    // Extra pointer MSB distinguishes full from empty.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/jacobi_feeder.sv
// Feeds a Jacobi solver: a go strobe, then N B-words and N*N A-words, each
// presented with a one-cycle load strobe, taken from a buffered input stream.
module jacobi_feeder
    import jacobi_feeder_pkg::*;
#(
    parameter int DATA_W     = FEEDER_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              go,
    output logic              load_B,
    output logic              load_A,
    output logic [DATA_W-1:0] B_next,
    output logic [DATA_W-1:0] A_next,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic [3:0]        state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [15:0]       nn_q, nn_d;
    logic [7:0]        b_cnt_q, b_cnt_d;
    logic [15:0]       a_cnt_q, a_cnt_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              go_q, go_d;
    logic              load_b_q, load_b_d;
    logic              load_a_q, load_a_d;
    logic [DATA_W-1:0] b_next_q, b_next_d;
    logic [DATA_W-1:0] a_next_q, a_next_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_pop_s;
    logic              fifo_push_s;
    logic [DATA_W-1:0] fifo_rdata_s;

    assign s_ready     = rst_n && !fifo_full_s;
    assign fifo_push_s = s_valid && s_ready;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push_s),
        .wdata (s_data),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Outputs are registered, so each strobe appears the cycle after its state decides it.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        nn_d       = nn_q;
        b_cnt_d    = b_cnt_q;
        a_cnt_d    = a_cnt_q;
        gap_d      = gap_q;
        go_d       = 1'b0;
        load_b_d   = 1'b0;
        load_a_d   = 1'b0;
        b_next_d   = b_next_q;
        a_next_d   = a_next_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        fifo_pop_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (n_is_valid(n)) begin
                        n_d     = n;
                        nn_d    = 16'(n) * 16'(n);
                        b_cnt_d = 8'd0;
                        a_cnt_d = 16'd0;
                        busy_d  = 1'b1;
                        go_d    = 1'b1;
                        state_d = ST_GO_HI;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GO_HI: begin
                gap_d   = '0;
                state_d = ST_GO_GAP;
            end
            ST_GO_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = ST_B_HI;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_B_HI: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    b_next_d   = fifo_rdata_s;
                    load_b_d   = 1'b1;
                    b_cnt_d    = b_cnt_q + 8'd1;
                    state_d    = ST_B_LO;
                end else begin
                    state_d = ST_B_HI;
                end
            end
            ST_B_LO: begin
                if (b_cnt_q == n_q) begin
                    gap_d   = '0;
                    state_d = ST_AB_GAP;
                end else begin
                    state_d = ST_B_HI;
                end
            end
            ST_AB_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = ST_A_HI;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_A_HI: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    a_next_d   = fifo_rdata_s;
                    load_a_d   = 1'b1;
                    a_cnt_d    = a_cnt_q + 16'd1;
                    state_d    = ST_A_LO;
                end else begin
                    state_d = ST_A_HI;
                end
            end
            ST_A_LO: begin
                if (a_cnt_q == nn_q) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_A_HI;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            n_q      <= 8'd0;
            nn_q     <= 16'd0;
            b_cnt_q  <= 8'd0;
            a_cnt_q  <= 16'd0;
            gap_q    <= '0;
            go_q     <= 1'b0;
            load_b_q <= 1'b0;
            load_a_q <= 1'b0;
            b_next_q <= '0;
            a_next_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            nn_q     <= nn_d;
            b_cnt_q  <= b_cnt_d;
            a_cnt_q  <= a_cnt_d;
            gap_q    <= gap_d;
            go_q     <= go_d;
            load_b_q <= load_b_d;
            load_a_q <= load_a_d;
            b_next_q <= b_next_d;
            a_next_q <= a_next_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign go     = go_q;
    assign load_B = load_b_q;
    assign load_A = load_a_q;
    assign B_next = b_next_q;
    assign A_next = a_next_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_jacobi_feeder.sv
// Scoreboard bench for jacobi_feeder: stimulus queues expected B/A words,
// a negedge monitor pops and compares them on every strobe rising edge.
module tb_jacobi_feeder;

    localparam int DW  = 27;
    localparam int GAP = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          go;
    logic          load_B;
    logic          load_A;
    logic [DW-1:0] B_next;
    logic [DW-1:0] A_next;
    logic          busy;
    logic          done;
    logic          err;

    jacobi_feeder #(.DATA_W(DW), .FIFO_DEPTH(4), .GAP_CYCLES(GAP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .n       (n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .go      (go),
        .load_B  (load_B),
        .load_A  (load_A),
        .B_next  (B_next),
        .A_next  (A_next),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] src_q [$];
    logic [DW-1:0] exp_b [$];
    logic [DW-1:0] exp_a [$];
    int checks = 0;
    int failures = 0;
    int go_seen = 0, b_seen = 0, a_seen = 0, done_seen = 0;
    bit throttle = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Source driver: presents src_q head, optionally only every other cycle.
    initial begin
        bit tog;
        tog = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        forever begin
            @(posedge clk);
            if (s_valid && s_ready) void'(src_q.pop_front());
            #2;
            tog = throttle ? ~tog : 1'b1;
            if (src_q.size() > 0 && tog) begin
                s_valid = 1'b1;
                s_data = src_q[0];
            end else begin
                s_valid = 1'b0;
                s_data = '0;
            end
        end
    end

    // Monitor: scoreboard pops on strobe rising edges plus protocol checks.
    initial begin
        logic p_go, p_lb, p_la, p_done, p_busy;
        logic [DW-1:0] p_b, p_a;
        int cyc, go_cyc, lastb_cyc;
        bit b_first, a_first;
        p_go = 0; p_lb = 0; p_la = 0; p_done = 0; p_busy = 0; p_b = '0; p_a = '0;
        cyc = 0; go_cyc = 0; lastb_cyc = 0; b_first = 0; a_first = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (go && !p_go) begin
                    go_seen++; go_cyc = cyc; b_first = 1; a_first = 1;
                end
                if (load_B) chk("load_B_one_cycle", p_lb, 0);
                if (load_A) chk("load_A_one_cycle", p_la, 0);
                if (load_B && load_A) chk("strobes_exclusive", 1, 0);
                if (load_B && !p_lb) begin
                    b_seen++;
                    if (exp_b.size() == 0) chk("B_unexpected_strobe", B_next, -1);
                    else chk("B_data", B_next, exp_b.pop_front());
                    if (b_first) begin
                        chk("go_to_first_B_latency", (cyc - go_cyc) >= GAP + 1, 1);
                        b_first = 0;
                    end
                    lastb_cyc = cyc;
                end
                if (load_A && !p_la) begin
                    a_seen++;
                    if (exp_a.size() == 0) chk("A_unexpected_strobe", A_next, -1);
                    else chk("A_data", A_next, exp_a.pop_front());
                    if (a_first) begin
                        chk("B_to_A_gap", (cyc - lastb_cyc - 1) >= GAP, 1);
                        a_first = 0;
                    end
                end
                if (B_next !== p_b) chk("B_next_changes_only_on_strobe", load_B && !p_lb, 1);
                if (A_next !== p_a) chk("A_next_changes_only_on_strobe", load_A && !p_la, 1);
                if (done) begin
                    done_seen++;
                    chk("done_one_cycle", p_done, 0);
                    chk("busy_falls_with_done", {p_busy, busy}, 2'b10);
                end
            end
            p_go = go; p_lb = load_B; p_la = load_A; p_done = done; p_busy = busy;
            p_b = B_next; p_a = A_next;
        end
    end

    task automatic push_b(input logic [DW-1:0] w);
        src_q.push_back(w);
        exp_b.push_back(w);
    endtask

    task automatic push_a(input logic [DW-1:0] w);
        src_q.push_back(w);
        exp_a.push_back(w);
    endtask

    task automatic pulse_start(input logic [7:0] nv);
        @(posedge clk); #1;
        start = 1'b1; n = nv;
        @(posedge clk); #1;
        start = 1'b0; n = 8'd0;
    endtask

    task automatic wait_done(input int bound);
        int base, k;
        base = done_seen; k = 0;
        while (done_seen == base && k < bound) begin
            @(posedge clk); k++;
        end
        #1;
        chk("done_count", done_seen - base, 1);
    endtask

    task automatic check_counts(input string name, input int g0, input int b0, input int a0,
                                input int g, input int b, input int a);
        chk({name, "_go"}, go_seen - g0, g);
        chk({name, "_B"}, b_seen - b0, b);
        chk({name, "_A"}, a_seen - a0, a);
        chk({name, "_busy_low"}, busy, 0);
        chk({name, "_exp_B_drained"}, exp_b.size(), 0);
        chk({name, "_exp_A_drained"}, exp_a.size(), 0);
    endtask

    initial begin
        int g0, b0, a0, k;
        rst_n = 1'b0; start = 1'b0; n = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl_outputs", {go, load_B, load_A, busy, done, err, s_ready}, 0);
        chk("reset_B_next", B_next, 0);
        chk("reset_A_next", A_next, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // n=2, words queued while idle: FIFO fills and back-pressures.
        push_b(27'h100); push_b(27'h200);
        push_a(27'h400); push_a(27'h100); push_a(27'h100); push_a(27'h400);
        repeat (8) @(posedge clk);
        #1 chk("idle_fifo_full_s_ready", s_ready, 0);
        g0 = go_seen; b0 = b_seen; a0 = a_seen;
        pulse_start(8'd2);
        chk("busy_after_start", busy, 1);
        wait_done(200);
        check_counts("n2", g0, b0, a0, 1, 2, 4);

        // n=3 with the source valid only every other cycle.
        throttle = 1'b1;
        push_b(27'h0000100); push_b(27'h7FFFF00); push_b(27'h0000280);
        for (int i = 1; i <= 9; i++) push_a(DW'(i * 32'h111));
        g0 = go_seen; b0 = b_seen; a0 = a_seen;
        pulse_start(8'd3);
        wait_done(400);
        check_counts("n3_throttled", g0, b0, a0, 1, 3, 9);
        throttle = 1'b0;

        // Out-of-range n sets the sticky error and starts nothing.
        g0 = go_seen; b0 = b_seen; a0 = a_seen;
        pulse_start(8'd0);
        chk("err_after_n0", err, 1);
        chk("busy_after_n0", busy, 0);
        pulse_start(8'd201);
        repeat (10) @(posedge clk);
        #1;
        chk("err_after_n201", err, 1);
        check_counts("bad_n", g0, b0, a0, 0, 0, 0);

        // Second start during the B phase is ignored.
        push_b(27'h011); push_b(27'h022);
        push_a(27'h033); push_a(27'h044); push_a(27'h055); push_a(27'h066);
        g0 = go_seen; b0 = b_seen; a0 = a_seen;
        pulse_start(8'd2);
        k = 0;
        while (b_seen == b0 && k < 100) begin @(posedge clk); k++; end
        chk("wait_first_B", b_seen - b0, 1);
        pulse_start(8'd3);
        wait_done(200);
        check_counts("restart_ignored", g0, b0, a0, 1, 2, 4);
        chk("err_still_sticky", err, 1);

        // Reset in the A phase after two A strobes.
        push_b(27'h1A0); push_b(27'h1B0);
        push_a(27'h2A0); push_a(27'h2B0); push_a(27'h2C0); push_a(27'h2D0);
        a0 = a_seen;
        pulse_start(8'd2);
        k = 0;
        while (a_seen - a0 < 2 && k < 200) begin @(posedge clk); k++; end
        chk("wait_two_A", a_seen - a0, 2);
        #1;
        rst_n = 1'b0;
        src_q.delete(); exp_a.delete(); exp_b.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midreset_ctrl_outputs", {go, load_B, load_A, busy, done, err, s_ready}, 0);
        chk("midreset_B_next", B_next, 0);
        chk("midreset_A_next", A_next, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // n=1 after reset: stale FIFO contents would show up as wrong data.
        push_b(27'h7FFFF00); push_a(27'h080);
        g0 = go_seen; b0 = b_seen; a0 = a_seen;
        pulse_start(8'd1);
        wait_done(200);
        check_counts("n1_after_reset", g0, b0, a0, 1, 1, 1);
        chk("err_cleared_by_reset", err, 0);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
